// File: rtl/fetch_byte_queue_pkg.sv
// Shared fetch/decode constants and the carry-lookahead adder used by the
// byte queue counters.
package fetch_byte_queue_pkg;

   localparam int unsigned CntW       = 6;    // byte-count width (0..32)
   localparam int unsigned LineW      = 128;  // one instruction line
   localparam int unsigned LineBytes  = 16;
   localparam int unsigned QueueBytes = 32;
   localparam int unsigned QueueW     = QueueBytes * 8;
   localparam int unsigned ShAmtW     = 5;    // shift amount / per-line byte count
   localparam int unsigned ClaW       = 64;   // widest operand the adder handles

   // Parallel-prefix (Kogge-Stone) carry-lookahead adder. Narrower operands are
   // zero-extended by the caller and the result is cast back down.
   function automatic logic [ClaW-1:0] cla_add(input logic [ClaW-1:0] a,
                                               input logic [ClaW-1:0] b,
                                               input logic            cin);
      logic [ClaW-1:0] p;
      logic [ClaW-1:0] g;
      logic [ClaW-1:0] gp;
      logic [ClaW-1:0] pp;
      logic [ClaW-1:0] c;
      p  = a ^ b;
      g  = a & b;
      gp = g;
      pp = p;
      // Descending index keeps the lower (not yet updated) level values intact.
      for (int d = 1; d < int'(ClaW); d = d * 2) begin
         for (int i = int'(ClaW) - 1; i >= d; i--) begin
            gp[i] = gp[i] | (pp[i] & gp[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      c[0] = cin;
      for (int i = 1; i < int'(ClaW); i++) begin
         c[i] = gp[i-1] | (pp[i-1] & cin);
      end
      return p ^ c;
   endfunction

endpackage

// File: rtl/fbq_byte_shifter_32B.sv
// 32-byte logarithmic byte shifter. Left variant retires head bytes; the right
// variant positions an incoming line behind the bytes already queued.
module fbq_byte_shifter_32B
   import fetch_byte_queue_pkg::*;
#(
   parameter bit ShiftRight = 1'b0
) (
   input  logic [QueueW-1:0] data,
   input  logic [ShAmtW-1:0] amount,
   output logic [QueueW-1:0] result
);

   logic [QueueW-1:0] stage [0:ShAmtW];

   assign stage[0] = data;

   // Stage s shifts by 2^s bytes when amount[s] is set; vacated bytes are zero.
   for (genvar s = 0; s < int'(ShAmtW); s++) begin : g_stage
      localparam int unsigned Bits = 8 << s;
      if (ShiftRight) begin : g_right
         assign stage[s+1] = amount[s] ? (stage[s] >> Bits) : stage[s];
      end else begin : g_left
         assign stage[s+1] = amount[s] ? (stage[s] << Bits) : stage[s];
      end
   end

   assign result = stage[ShAmtW];

endmodule

// File: rtl/fetch_byte_queue.sv
// Fetch-side byte queue: buffers 16-byte cache lines, presents the oldest 16
// bytes MSB-first to decode and retires a variable byte count per handshake.
// Bytes beyond count are always zero in the buffer, so the head window needs
// no output masking. IADDRW is limited to 64 by the shared adder.
module fetch_byte_queue
   import fetch_byte_queue_pkg::*;
#(
   parameter int unsigned        IADDRW   = 32,
   parameter logic [IADDRW-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [IADDRW-1:0] flush_pc,
   input  logic              ic_valid,
   output logic              ic_ready,
   input  logic [LineW-1:0]  ic_line,
   input  logic              ic_branch_taken,
   output logic              f_valid,
   input  logic              f_ready,
   input  logic [CntW-1:0]   f_bytes_read,
   output logic [CntW:0]     f_valid_bytes,
   output logic [LineW-1:0]  f_instruction,
   output logic [IADDRW-1:0] f_pc,
   output logic              f_branch_taken
);

   localparam logic [CntW-1:0]   LineCnt = CntW'(LineBytes);
   localparam logic [ShAmtW-1:0] LineAmt = ShAmtW'(LineBytes);

   logic [QueueW-1:0] qbuf_q, qbuf_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [IADDRW-1:0] head_pc_q, head_pc_d;
   logic [ShAmtW-1:0] head_left_q, head_left_d;
   logic              head_tag_q, head_tag_d;
   logic              next_tag_q, next_tag_d;
   logic [3:0]        skip_q, skip_d;

   logic [ShAmtW-1:0] avail;
   logic [CntW-1:0]   rd_req;
   logic [ShAmtW-1:0] rd;
   logic [CntW-1:0]   cnt_r;
   logic [ShAmtW-1:0] line_len;
   logic              accept;
   logic [ShAmtW-1:0] rem;
   logic [ShAmtW-1:0] take_len;
   logic [ShAmtW-1:0] left_r;
   logic              tag_r;
   logic [QueueW-1:0] kept;
   logic [QueueW-1:0] line_al;
   logic [QueueW-1:0] line_ins;

   // Outputs depend only on registered state (flush alone may raise ic_ready).
   always_comb begin
      avail          = (count_q > LineCnt) ? LineAmt : count_q[ShAmtW-1:0];
      f_valid        = (count_q != '0);
      f_valid_bytes  = (CntW+1)'(avail);
      f_instruction  = qbuf_q[QueueW-1 -: LineW];
      f_pc           = head_pc_q;
      f_branch_taken = head_tag_q;
      ic_ready       = (count_q <= LineCnt) || flush;
   end

   // Retire amount, post-retire count and line acceptance.
   always_comb begin
      rd_req = (f_valid && f_ready) ? f_bytes_read : '0;
      // An over-read is clamped to what is actually presented.
      rd       = (rd_req > CntW'(avail)) ? avail : rd_req[ShAmtW-1:0];
      cnt_r    = CntW'(cla_add(ClaW'(count_q), ~ClaW'(rd), 1'b1));
      line_len = ShAmtW'(cla_add(ClaW'(LineBytes), ~ClaW'(skip_q), 1'b1));
      accept   = ic_valid && ic_ready && !flush;
   end

   // Head-line bookkeeping after retire: roll into the next line once the
   // current one is used up.
   always_comb begin
      rem      = '0;
      take_len = '0;
      left_r   = head_left_q;
      tag_r    = head_tag_q;
      if ((rd != '0) && (rd >= head_left_q)) begin
         rem      = ShAmtW'(cla_add(ClaW'(rd), ~ClaW'(head_left_q), 1'b1));
         take_len = ShAmtW'(cla_add(ClaW'(LineBytes), ~ClaW'(rem), 1'b1));
         left_r   = (CntW'(take_len) > cnt_r) ? cnt_r[ShAmtW-1:0] : take_len;
         tag_r    = next_tag_q;
      end else begin
         left_r = ShAmtW'(cla_add(ClaW'(head_left_q), ~ClaW'(rd), 1'b1));
      end
   end

   fbq_byte_shifter_32B #(
      .ShiftRight (1'b0)
   ) u_retire_shift (
      .data   (qbuf_q),
      .amount (rd),
      .result (kept)
   );

   // Drop the leading skip bytes of a line entered mid-line after a redirect.
   fbq_byte_shifter_32B #(
      .ShiftRight (1'b0)
   ) u_skip_shift (
      .data   ({ic_line, {LineW{1'b0}}}),
      .amount ({1'b0, skip_q}),
      .result (line_al)
   );

   // Place the line right after the surviving bytes (cnt_r <= 16 on accept).
   fbq_byte_shifter_32B #(
      .ShiftRight (1'b1)
   ) u_insert_shift (
      .data   (line_al),
      .amount (cnt_r[ShAmtW-1:0]),
      .result (line_ins)
   );

   // Next-state: retire, fill, tags; flush overrides everything.
   always_comb begin
      qbuf_d      = kept | (accept ? line_ins : '0);
      count_d     = cnt_r;
      head_pc_d   = IADDRW'(cla_add(ClaW'(head_pc_q), ClaW'(rd), 1'b0));
      head_left_d = left_r;
      head_tag_d  = tag_r;
      next_tag_d  = next_tag_q;
      skip_d      = skip_q;
      if (accept) begin
         count_d = CntW'(cla_add(ClaW'(cnt_r), ClaW'(line_len), 1'b0));
         skip_d  = '0;
         if (left_r == '0) begin
            head_left_d = line_len;
            head_tag_d  = ic_branch_taken;
         end else begin
            next_tag_d = ic_branch_taken;
         end
      end
      if (flush) begin
         qbuf_d      = '0;
         count_d     = '0;
         head_pc_d   = flush_pc;
         head_left_d = '0;
         head_tag_d  = 1'b0;
         next_tag_d  = 1'b0;
         skip_d      = flush_pc[3:0];
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qbuf_q      <= '0;
         count_q     <= '0;
         head_pc_q   <= RESET_PC;
         head_left_q <= '0;
         head_tag_q  <= 1'b0;
         next_tag_q  <= 1'b0;
         skip_q      <= RESET_PC[3:0];
      end else begin
         qbuf_q      <= qbuf_d;
         count_q     <= count_d;
         head_pc_q   <= head_pc_d;
         head_left_q <= head_left_d;
         head_tag_q  <= head_tag_d;
         next_tag_q  <= next_tag_d;
         skip_q      <= skip_d;
      end
   end

endmodule
